// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared types and constants for the program loader
package im_loader_pkg;

   localparam int LEN_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      CHK,
      DONE,
      ERR
   } state_e;

   typedef enum logic [1:0] {
      ERR_CHK   = 2'd0,
      ERR_EMPTY = 2'd1,
      ERR_OVF   = 2'd2,
      ERR_ALIGN = 2'd3
   } err_code_e;

endpackage

// File: rtl/im_loader.sv
// rtl/im_loader.sv - framed byte-stream loader writing the instruction memory
// Holds the core in reset until a frame with a valid length and checksum lands.
module im_loader
   import im_loader_pkg::*;
#(
   parameter int MEM_BYTES     = 1024,
   parameter int ADDR_W        = 10,
   parameter int BASE_ADDR     = 0,
   parameter bit HOLD_AT_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [7:0]        wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   byte_cnt
);

   localparam int unsigned CAP = MEM_BYTES - BASE_ADDR;

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [7:0]        chk_q, chk_d;
   logic [ADDR_W:0]   byte_cnt_q, byte_cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   err_code_e         err_code_q, err_code_d;
   logic              cpu_hold_q, cpu_hold_d;

   logic              accept;
   logic [LEN_W-1:0]  len_full;

   // s_ready depends on registered state only, never on s_valid
   assign busy     = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                     (state_q == DATA)   || (state_q == CHK);
   assign s_ready  = busy;
   assign accept   = s_valid && s_ready;
   assign len_full = {len_q[15:8], s_data};

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      chk_d      = chk_q;
      byte_cnt_d = byte_cnt_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      done_d     = done_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      cpu_hold_d = cpu_hold_q;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d    = LEN_HI;
               chk_d      = 8'h00;
               byte_cnt_d = '0;
               done_d     = 1'b0;
               err_d      = 1'b0;
               cpu_hold_d = 1'b1;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d[15:8] = s_data;
               chk_d       = chk_q ^ s_data;
               state_d     = LEN_LO;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_d = len_full;
               chk_d = chk_q ^ s_data;
               if (len_full == '0) begin
                  state_d    = ERR;
                  err_d      = 1'b1;
                  err_code_d = ERR_EMPTY;
               end else if (32'(len_full) > CAP) begin
                  state_d    = ERR;
                  err_d      = 1'b1;
                  err_code_d = ERR_OVF;
               end else if (len_full[1:0] != 2'b00) begin
                  state_d    = ERR;
                  err_d      = 1'b1;
                  err_code_d = ERR_ALIGN;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               we_d       = 1'b1;
               waddr_d    = ADDR_W'(BASE_ADDR) + byte_cnt_q[ADDR_W-1:0];
               wdata_d    = s_data;
               chk_d      = chk_q ^ s_data;
               byte_cnt_d = byte_cnt_q + 1'b1;
               if (LEN_W'(byte_cnt_q) == len_q - 1'b1) begin
                  state_d = CHK;
               end
            end
         end
         CHK: begin
            if (accept) begin
               chk_d = chk_q ^ s_data;
               if ((chk_q ^ s_data) == 8'h00) begin
                  state_d    = DONE;
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
               end else begin
                  state_d    = ERR;
                  err_d      = 1'b1;
                  err_code_d = ERR_CHK;
                  cpu_hold_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         chk_q      <= 8'h00;
         byte_cnt_q <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= 8'h00;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_CHK;
         cpu_hold_q <= HOLD_AT_RESET;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         chk_q      <= chk_d;
         byte_cnt_q <= byte_cnt_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         cpu_hold_q <= cpu_hold_d;
      end
   end

   assign we       = we_q;
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;
   assign done     = done_q;
   assign err      = err_q;
   assign err_code = err_code_q;
   assign cpu_hold = cpu_hold_q;
   assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - scoreboard bench for im_loader
module tb_im_loader;

   localparam int ADDR_W    = 10;
   localparam int MEM_BYTES = 1024;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              s_valid = 1'b0;
   logic [7:0]        s_data = 8'h00;
   logic              s_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [7:0]        wdata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              err;
   logic [1:0]        err_code;
   logic [ADDR_W:0]   byte_cnt;

   im_loader #(
      .MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .BASE_ADDR(0), .HOLD_AT_RESET(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
      .busy(busy), .done(done), .err(err), .err_code(err_code), .byte_cnt(byte_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   logic [17:0] exp_wr_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Write monitor: every we pulse must match the oldest expected write
   always @(negedge clk) begin
      if (rst_n && we) begin
         if (exp_wr_q.size() == 0) begin
            check("we_unexpected", 32'(we), 32'd0);
         end else begin
            logic [17:0] e;
            e = exp_wr_q.pop_front();
            check("waddr", 32'(waddr), 32'(e[17:8]));
            check("wdata", 32'(wdata), 32'(e[7:0]));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, output bit ok);
      int n = 0;
      s_valid = 1'b1;
      s_data  = b;
      while (!s_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         check("s_ready_timeout", 32'd0, 32'd1);
         s_valid = 1'b0;
         ok = 1'b0;
         return;
      end
      @(negedge clk);
      s_valid = 1'b0;
      ok = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_cpu_hold", 32'(cpu_hold), 32'd1);
      check("start_s_ready", 32'(s_ready), 32'd1);
      check("start_busy", 32'(busy), 32'd1);
   endtask

   // Reference model: classify the frame from its length, then expect writes and status
   task automatic run_frame(input logic [15:0] len, input logic [7:0] payload[$],
                            input logic [7:0] chk_flip, input int gap_min, input int gap_max,
                            input int start_idx);
      bit         ok;
      bit         hdr_err;
      logic [7:0] x;
      logic [1:0] exp_code;
      bit         exp_done;
      hdr_err  = 1'b1;
      exp_done = 1'b0;
      if (len == 0) exp_code = 2'd1;
      else if (int'(len) > MEM_BYTES) exp_code = 2'd2;
      else if (len % 4 != 0) exp_code = 2'd3;
      else begin
         hdr_err  = 1'b0;
         exp_code = 2'd0;
         exp_done = (chk_flip == 8'h00);
      end
      x = len[15:8] ^ len[7:0];
      if (!hdr_err) begin
         for (int i = 0; i < int'(len); i++) begin
            x ^= payload[i];
            exp_wr_q.push_back({ADDR_W'(i), payload[i]});
         end
      end
      pulse_start();
      send_byte(len[15:8], ok);
      if (ok) send_byte(len[7:0], ok);
      if (ok && !hdr_err) begin
         for (int i = 0; i < int'(len) && ok; i++) begin
            repeat ($urandom_range(gap_min, gap_max)) @(negedge clk);
            if (i == start_idx) start = 1'b1;
            send_byte(payload[i], ok);
            start = 1'b0;
         end
         repeat ($urandom_range(gap_min, gap_max)) @(negedge clk);
         if (ok) send_byte(x ^ chk_flip, ok);
      end
      check("end_done", 32'(done), 32'(exp_done));
      check("end_err", 32'(err), 32'(!exp_done));
      if (!exp_done) check("end_err_code", 32'(err_code), 32'(exp_code));
      check("end_cpu_hold", 32'(cpu_hold), 32'(!exp_done));
      check("end_byte_cnt", 32'(byte_cnt), hdr_err ? 32'd0 : 32'(len));
      check("end_s_ready", 32'(s_ready), 32'd0);
      if (hdr_err) check("hdr_no_we", 32'(we), 32'd0);
      @(negedge clk);
      check("writes_drained", 32'(exp_wr_q.size()), 32'd0);
      exp_wr_q.delete();
   endtask

   initial begin
      logic [7:0] good[$];
      logic [7:0] none[$];
      logic [7:0] pl[$];
      logic [15:0] len;
      logic [7:0] flip;
      int sidx;
      bit ok;
      good = '{8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h01, 8'h13};

      repeat (3) @(negedge clk);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_we", 32'(we), 32'd0);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
      check("rst_flags", {29'd0, done, err, busy}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_frame(16'd8, good, 8'h00, 0, 0, -1);
      run_frame(16'd8, good, 8'h01, 0, 0, -1);
      run_frame(16'h0000, none, 8'h00, 0, 0, -1);
      run_frame(16'h0404, none, 8'h00, 0, 0, -1);
      run_frame(16'h0006, none, 8'h00, 0, 0, -1);
      run_frame(16'd8, good, 8'h00, 1, 1, -1);
      run_frame(16'd8, good, 8'h00, 0, 0, 3);

      // Asynchronous reset after three payload bytes
      pulse_start();
      send_byte(8'h00, ok);
      send_byte(8'h08, ok);
      for (int i = 0; i < 3; i++) begin
         exp_wr_q.push_back({ADDR_W'(i), good[i]});
         send_byte(good[i], ok);
      end
      #1 rst_n = 1'b0;
      #1;
      check("midrst_we", 32'(we), 32'd0);
      check("midrst_byte_cnt", 32'(byte_cnt), 32'd0);
      check("midrst_idle", {30'd0, busy, s_ready}, 32'd0);
      check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      exp_wr_q.delete();
      @(negedge clk);
      run_frame(16'd8, good, 8'h00, 0, 0, -1);
      check("done_cpu_hold_low", 32'(cpu_hold), 32'd0);

      for (int f = 0; f < 25; f++) begin
         case ($urandom_range(0, 9))
            0: len = 16'd0;
            1: len = 16'($urandom_range(MEM_BYTES + 1, 65535));
            2: len = 16'(4 * $urandom_range(0, 20) + $urandom_range(1, 3));
            default: len = 16'(4 * $urandom_range(1, 16));
         endcase
         pl.delete();
         if (int'(len) <= MEM_BYTES)
            for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom_range(0, 255)));
         flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         sidx = ($urandom_range(0, 3) == 0 && len != 0) ? int'($urandom_range(0, 3)) : -1;
         run_frame(len, pl, flip, 0, 2, sidx);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
